// File: rtl/button_debounce_pkg.sv
// Shared timing constants for the push-button conditioner, derived from the common clock definition.
// Filter/repeat defaults are expressed in core clock cycles so the stopwatch core and this block agree.
package button_debounce_pkg;

  localparam int FRQ_HZ      = 24000;
  localparam int DBN_MS      = 10;
  localparam int DEF_SYN     = 2;
  localparam int DEF_DBN     = FRQ_HZ * DBN_MS / 1000;
  localparam int DEF_RPT_DLY = 10 * DEF_DBN;
  localparam int DEF_RPT_PER = 2 * DEF_DBN;

  typedef struct packed {
    logic lvl;
    logic prs;
  } btn_out_t;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Pin-side bundle of the button conditioner: raw pins in, debounced level and press pulse out.
interface button_debounce_if #(
  parameter int BTN = 2
);

  logic [BTN-1:0] btn_raw;
  logic [BTN-1:0] btn_lvl;
  logic [BTN-1:0] btn_prs;

  modport master (
    output btn_raw,
    input  btn_lvl,
    input  btn_prs
  );

  modport slave (
    input  btn_raw,
    output btn_lvl,
    output btn_prs
  );

endinterface

// File: rtl/button_debounce_cell.sv
// One button: synchroniser, stability filter, registered press pulse, optional auto-repeat.
// Auto-repeat is built only when BUTTON_DEBOUNCE_REPEAT_EN is defined.
module button_debounce_cell
  import button_debounce_pkg::*;
#(
  parameter int SYN     = DEF_SYN,
  parameter int DBN     = DEF_DBN,
  parameter int RPT_DLY = DEF_RPT_DLY,
  parameter int RPT_PER = DEF_RPT_PER
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     raw,
  output btn_out_t res
);

  localparam int             CW       = cnt_w(DBN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DBN - 1);

  if (SYN < 2 || DBN < 1 || RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_cfg
    $error("button_debounce_cell: SYN must be >= 2, DBN/RPT_DLY/RPT_PER >= 1");
  end

  logic [SYN-1:0] sync;
  logic           s;
  logic [CW-1:0]  cnt;
  logic           lvl;
  logic           prs;
  logic           accept;
  logic           rpt;

  assign s      = sync[SYN-1];
  assign accept = (s != lvl) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      lvl  <= 1'b0;
    end else begin
      sync <= {sync[SYN-2:0], raw};
      if (s == lvl) begin
        cnt <= '0;
      end else if (accept) begin
        lvl <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int            RW       = cnt_w((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER);
  localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER - 1);

  logic [RW-1:0] rcnt;
  logic          rph;

  // rcnt counts cycles since the last pulse; rph selects the initial delay or the repeat period.
  assign rpt = lvl && !accept && (rcnt == (rph ? PER_LAST : DLY_LAST));

  always_ff @(posedge clk) begin
    if (rst || !lvl || accept) begin
      rcnt <= '0;
      rph  <= 1'b0;
    end else if (rpt) begin
      rcnt <= '0;
      rph  <= 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign rpt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prs <= 1'b0;
    end else begin
      prs <= (accept && s) || rpt;
    end
  end

  assign res.lvl = lvl;
  assign res.prs = prs;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner for the stopwatch core: BTN independent debounce cells packed onto one bundle.
// Optional auto-repeat via macro BUTTON_DEBOUNCE_REPEAT_EN; latency SYN+DBN cycles from a clean pin edge.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int BTN     = 2,
  parameter int SYN     = DEF_SYN,
  parameter int DBN     = DEF_DBN,
  parameter int RPT_DLY = DEF_RPT_DLY,
  parameter int RPT_PER = DEF_RPT_PER
) (
  input logic              clk,
  input logic              rst,
  button_debounce_if.slave bus
);

  for (genvar i = 0; i < BTN; i++) begin : g_btn
    btn_out_t res;

    button_debounce_cell #(
      .SYN     (SYN),
      .DBN     (DBN),
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .raw (bus.btn_raw[i]),
      .res (res)
    );

    assign bus.btn_lvl[i] = res.lvl;
    assign bus.btn_prs[i] = res.prs;
  end

endmodule
